// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;

  // Port identifiers: P0 is the CPU, P1 is the loader/debug port.
  typedef enum logic {
    P0 = 1'b0,
    P1 = 1'b1
  } port_t;

  localparam int AW_DEF       = 16;
  localparam int DW_DEF       = 16;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: combinational grant with lock/round-robin
// priority, a bounded lock hold so neither port starves, and a one-cycle
// rvalid pipeline matching the memory's registered read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] Data_in,
  input  logic [DW-1:0] Data_out
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

  // Hold counter increment that sticks at the top value.
  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v == HOLD_TOP) ? v : v + 1'b1;
  endfunction

  port_t          last;
  port_t          prev_owner;
  logic           lock_q;
  logic [HW-1:0]  hold_cnt;
  logic           vld0_p1;
  logic           vld1_p1;

  port_t          sel;
  logic           any_gnt;
  logic           sel_lock;
  logic           own_req;
  logic           oth_req;
  logic           keep;

  // Grant decision: locked owner first, then lone requester, then round-robin.
  always_comb begin
    sel      = P0;
    any_gnt  = 1'b0;
    own_req  = (prev_owner == P0) ? req0 : req1;
    oth_req  = (prev_owner == P0) ? req1 : req0;
    keep     = lock_q && own_req && ((hold_cnt < HOLD_TOP) || !oth_req);
    if (!reset) begin
      any_gnt = 1'b0;
    end else if (keep) begin
      sel     = prev_owner;
      any_gnt = 1'b1;
    end else if (req0 && req1) begin
      sel     = (last == P0) ? P1 : P0;
      any_gnt = 1'b1;
    end else if (req0) begin
      sel     = P0;
      any_gnt = 1'b1;
    end else if (req1) begin
      sel     = P1;
      any_gnt = 1'b1;
    end
    sel_lock = (sel == P0) ? lock0 : lock1;
  end

  assign gnt0     = any_gnt && (sel == P0);
  assign gnt1     = any_gnt && (sel == P1);
  assign MemWrite = (gnt0 && we0) || (gnt1 && we1);
  assign MemRead  = (gnt0 && !we0) || (gnt1 && !we1);
  assign ADDR     = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign Data_in  = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  // Read data comes straight from memory; rvalid alone marks ownership.
  assign rdata0  = Data_out;
  assign rdata1  = Data_out;
  assign rvalid0 = vld0_p1;
  assign rvalid1 = vld1_p1;

  // Arbitration history and the read-return pipeline stage (p0 -> p1).
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      last       <= P1;
      prev_owner <= P1;
      lock_q     <= 1'b0;
      hold_cnt   <= '0;
      vld0_p1    <= 1'b0;
      vld1_p1    <= 1'b0;
    end else begin
      vld0_p1 <= gnt0 && !we0;
      vld1_p1 <= gnt1 && !we1;
      lock_q  <= any_gnt && sel_lock;
      if (any_gnt) begin
        last       <= sel;
        prev_owner <= sel;
      end
      if (any_gnt && lock_q && (sel == prev_owner) && sel_lock)
        hold_cnt <= sat_inc(hold_cnt);
      else
        hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a registered memory model.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MAX_HOLD = 8;

  logic          CLK = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, MemRead, MemWrite;
  logic [DW-1:0] rdata0, rdata1, Data_in;
  logic [DW-1:0] Data_out = '0;
  logic [AW-1:0] ADDR;

  logic [DW-1:0] mem [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK(CLK), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR),
    .Data_in(Data_in), .Data_out(Data_out)
  );

  always #5 CLK = ~CLK;

  // Memory with one-cycle registered read.
  always @(posedge CLK) begin
    if (MemWrite) mem[ADDR[7:0]] <= Data_in;
    if (MemRead)  Data_out <= mem[ADDR[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  logic g0s, g1s, pend0, pend1;
  int   streak0, streak1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    idle();
    reset = 1'b0;
    req0  = 1'b1;
    @(negedge CLK);
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'(0));
    chk("rst_strobe", 32'({MemRead, MemWrite}), 32'(0));
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'(0));

    // Tie after reset: port 0 first, then port 1, with port 0's read data.
    step();
    reset = 1'b1;
    req0 = 1; req1 = 1; addr0 = 16'd25; addr1 = 16'd26;
    @(negedge CLK);
    chk("tie_gnt", 32'({gnt0, gnt1}), 32'(2'b10));
    chk("tie_addr", 32'(ADDR), 32'(25));
    chk("tie_rd", 32'(MemRead), 32'(1));
    step();
    @(negedge CLK);
    chk("rr_gnt", 32'({gnt0, gnt1}), 32'(2'b01));
    chk("rr_addr", 32'(ADDR), 32'(26));
    chk("rr_rv0", 32'({rvalid0, rvalid1}), 32'(2'b10));
    chk("rr_rdata0", 32'(rdata0), 32'(16'hA019));
    step();
    idle();
    @(negedge CLK);
    chk("rr_rv1", 32'({rvalid0, rvalid1}), 32'(2'b01));
    chk("rr_rdata1", 32'(rdata1), 32'(16'hA01A));
    chk("idle_bus", 32'({MemRead, MemWrite, ADDR}), 32'(0));

    // Lone requester on port 1, four back-to-back reads.
    for (int i = 0; i < 5; i++) begin
      step();
      idle();
      if (i < 4) begin
        req1 = 1; addr1 = 16'(30 + i);
      end
      @(negedge CLK);
      if (i < 4) begin
        chk("solo_gnt", 32'({gnt0, gnt1}), 32'(2'b01));
        chk("solo_rd", 32'(MemRead), 32'(1));
      end
      if (i > 0) begin
        chk("solo_rv", 32'({rvalid0, rvalid1}), 32'(2'b01));
        chk("solo_rdata", 32'(rdata1), 32'(16'hA000 + 29 + i));
      end
    end

    // Locked port 0 against a waiting port 1: 8 grants, then port 1.
    for (int i = 0; i < 10; i++) begin
      step();
      req0 = 1; req1 = 1; lock0 = 1; we0 = 1; we1 = 1;
      addr0 = 16'd100; addr1 = 16'd101;
      wdata0 = 16'(i); wdata1 = 16'(i + 16);
      @(negedge CLK);
      chk($sformatf("hold_gnt%0d", i), 32'({gnt0, gnt1}), (i == 8) ? 32'(2'b01) : 32'(2'b10));
      chk("hold_wr", 32'(MemWrite), 32'(1));
      chk("hold_norv", 32'({rvalid0, rvalid1}), 32'(0));
    end
    step();
    idle();
    @(negedge CLK);

    // Write by port 0, then read of the same address by port 1.
    step();
    req0 = 1; we0 = 1; addr0 = 16'd5; wdata0 = 16'h1234;
    @(negedge CLK);
    chk("raw_wgnt", 32'({gnt0, gnt1}), 32'(2'b10));
    chk("raw_wbus", 32'({MemWrite, MemRead, ADDR, Data_in}), {2'b10, 14'd0, 16'd5, 16'h1234});
    step();
    idle();
    req1 = 1; addr1 = 16'd5;
    @(negedge CLK);
    chk("raw_rgnt", 32'({gnt0, gnt1}), 32'(2'b01));
    chk("raw_wr_norv", 32'({rvalid0, rvalid1}), 32'(0));
    step();
    idle();
    @(negedge CLK);
    chk("raw_rv", 32'({rvalid0, rvalid1}), 32'(2'b01));
    chk("raw_rdata1", 32'(rdata1), 32'(16'h1234));
    chk("raw_rdata0", 32'(rdata0), 32'(16'h1234));
    step();
    @(negedge CLK);
    chk("raw_rv_once", 32'(rvalid1), 32'(0));

    // Reset right after a port-0 read grant kills its rvalid.
    step();
    req0 = 1; addr0 = 16'd25;
    @(negedge CLK);
    chk("mid_gnt", 32'(gnt0), 32'(1));
    step();
    reset = 1'b0;
    @(negedge CLK);
    chk("mid_rv", 32'({rvalid0, rvalid1}), 32'(0));
    chk("mid_strobe", 32'({gnt0, gnt1, MemRead, MemWrite}), 32'(0));
    step();
    @(negedge CLK);
    chk("mid_rv2", 32'({rvalid0, rvalid1, MemRead, MemWrite}), 32'(0));
    step();
    reset = 1'b1;
    idle();
    @(negedge CLK);
    chk("post_none", 32'({gnt0, gnt1, MemRead, MemWrite}), 32'(0));
    step();
    req0 = 1; req1 = 1;
    @(negedge CLK);
    chk("post_tie", 32'({gnt0, gnt1}), 32'(2'b10));
    step();
    idle();
    @(negedge CLK);
    step();
    @(negedge CLK);

    // Random traffic; requesters hold until granted.
    g0s = 0; g1s = 0; pend0 = 0; pend1 = 0; streak0 = 0; streak1 = 0;
    for (int c = 0; c < 10000; c++) begin
      step();
      if (!(req0 && !g0s)) begin
        req0 = ($urandom_range(0, 3) != 0);
        we0 = 1'($urandom_range(0, 1));
        addr0 = 16'($urandom_range(0, 255));
        wdata0 = 16'($urandom);
      end
      if (!(req1 && !g1s)) begin
        req1 = ($urandom_range(0, 3) != 0);
        we1 = 1'($urandom_range(0, 1));
        addr1 = 16'($urandom_range(0, 255));
        wdata1 = 16'($urandom);
      end
      lock0 = ($urandom_range(0, 3) != 0);
      lock1 = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      chk("rnd_onehot", 32'(gnt0 & gnt1), 32'(0));
      chk("rnd_gnt_req", 32'((gnt0 & ~req0) | (gnt1 & ~req1)), 32'(0));
      chk("rnd_rvalid", 32'({rvalid0, rvalid1}), 32'({pend0, pend1}));
      streak0 = (gnt0 && req1) ? streak0 + 1 : 0;
      streak1 = (gnt1 && req0) ? streak1 + 1 : 0;
      chk("rnd_starve", 32'((streak0 > MAX_HOLD) || (streak1 > MAX_HOLD)), 32'(0));
      pend0 = gnt0 & ~we0;
      pend1 = gnt1 & ~we1;
      g0s = gnt0;
      g1s = gnt1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
